// File: rtl/keypad_pkg.sv
// Shared types and widths for the keypad operand controller.
// Holds the FSM state encoding and the FP16 / digit-count widths.
package keypad_pkg;

  localparam int FP_W  = 16;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_DIGITS = CNT_W'(4);

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    ENTRY_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    RESULT  = 3'd4
  } state_t;

endpackage

// File: rtl/press_debounce.sv
// Level debouncer: one accept pulse after DEBOUNCE high samples,
// re-armed only after DEBOUNCE consecutive low samples.
module press_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic restart,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] eff;

  // a restart makes the current sample the first of a new run
  always_comb eff = restart ? '0 : cnt_q;

  assign accept = armed_q && level && (eff == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      cnt_q   <= '0;
    end else if (armed_q) begin
      if (!level) begin
        cnt_q <= '0;
      end else if (accept) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        cnt_q <= eff + 1'b1;
      end
    end else begin
      if (level) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        armed_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_operand_ctrl.sv
// Collects two hex FP16 operands from a keypad, launches an add
// and shows entry, operand or result on a 4-digit display.
module keypad_operand_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      key_value,
  input  logic            key_valid,
  input  logic            enter_btn,
  input  logic            clear_btn,
  output logic            add_start,
  output logic [FP_W-1:0] op_a,
  output logic [FP_W-1:0] op_b,
  input  logic            add_done,
  input  logic [FP_W-1:0] add_result,
  output logic [FP_W-1:0] display,
  output logic [2:0]      state,
  output logic [CNT_W-1:0] digit_cnt
);

  logic [1:0] ent_sync_q, clr_sync_q;
  logic [3:0] prev_key_q;
  logic       dig_ev, ent_ev, clr_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_sync_q <= '0;
      clr_sync_q <= '0;
      prev_key_q <= '0;
    end else begin
      ent_sync_q <= {ent_sync_q[0], enter_btn};
      clr_sync_q <= {clr_sync_q[0], clear_btn};
      prev_key_q <= key_value;
    end
  end

  press_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
    .clk(clk), .rst_n(rst_n), .level(key_valid),
    .restart(key_value != prev_key_q), .accept(dig_ev)
  );

  press_debounce #(.DEBOUNCE(DEBOUNCE)) u_ent (
    .clk(clk), .rst_n(rst_n), .level(ent_sync_q[1]),
    .restart(1'b0), .accept(ent_ev)
  );

  press_debounce #(.DEBOUNCE(DEBOUNCE)) u_clr (
    .clk(clk), .rst_n(rst_n), .level(clr_sync_q[1]),
    .restart(1'b0), .accept(clr_ev)
  );

  state_t          state_q, state_d;
  logic [FP_W-1:0] entry_q, entry_d, op_a_q, op_a_d;
  logic [FP_W-1:0] op_b_q, op_b_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0] shifted;
  logic [CNT_W-1:0] shifted_cnt;

  // digit is shifted in before any same-cycle enter commit
  always_comb begin
    shifted     = entry_q;
    shifted_cnt = cnt_q;
    if (dig_ev && cnt_q != MAX_DIGITS) begin
      shifted     = {entry_q[FP_W-5:0], key_value};
      shifted_cnt = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    if (clr_ev) begin
      state_d = ENTRY_A;
      entry_d = '0;
      cnt_d   = '0;
      op_a_d  = '0;
      op_b_d  = '0;
      res_d   = '0;
    end else begin
      unique case (state_q)
        ENTRY_A, ENTRY_B: begin
          entry_d = shifted;
          cnt_d   = shifted_cnt;
          if (ent_ev) begin
            entry_d = '0;
            cnt_d   = '0;
            if (state_q == ENTRY_A) begin
              op_a_d  = shifted;
              state_d = ENTRY_B;
            end else begin
              op_b_d  = shifted;
              state_d = START;
            end
          end
        end
        START: state_d = WAIT;
        WAIT: begin
          if (add_done) begin
            res_d   = add_result;
            state_d = RESULT;
          end
        end
        RESULT: begin
          if (dig_ev) begin
            entry_d = {12'h000, key_value};
            cnt_d   = CNT_W'(1);
            state_d = ENTRY_A;
          end
        end
        default: state_d = ENTRY_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY_A;
      entry_q <= '0;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    display = entry_q;
    unique case (state_q)
      START, WAIT: display = op_b_q;
      RESULT:      display = res_q;
      default:     display = entry_q;
    endcase
  end

  assign add_start = (state_q == START);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign state     = state_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_keypad_operand_ctrl.sv
// Directed bench for keypad_operand_ctrl with DEBOUNCE=4.
// Expected values are hand-computed constants.
module tb_keypad_operand_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_value = '0;
  logic        key_valid = 1'b0;
  logic        enter_btn = 1'b0;
  logic        clear_btn = 1'b0;
  logic        add_start;
  logic [15:0] op_a, op_b, display;
  logic        add_done = 1'b0;
  logic [15:0] add_result = '0;
  logic [2:0]  state;
  logic [2:0]  digit_cnt;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  bit found;

  keypad_operand_ctrl #(.DEBOUNCE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_value(key_value), .key_valid(key_valid),
    .enter_btn(enter_btn), .clear_btn(clear_btn),
    .add_start(add_start), .op_a(op_a), .op_b(op_b),
    .add_done(add_done), .add_result(add_result),
    .display(display), .state(state), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (add_start) starts++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input logic [3:0] v);
    @(negedge clk);
    key_value = v;
    key_valid = 1'b1;
    repeat (10) @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic enter();
    enter_btn = 1'b1;
    repeat (10) @(negedge clk);
    enter_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic clear();
    clear_btn = 1'b1;
    repeat (10) @(negedge clk);
    clear_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_disp", display, 0);
    check("rst_cnt", digit_cnt, 0);
    check("rst_ops", {op_a, op_b}, 0);
    check("rst_start", add_start, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    key(4'h3);
    check("one_key_disp", display, 16'h0003);
    check("one_key_cnt", digit_cnt, 1);

    @(negedge clk);
    key_value = 4'h5;
    key_valid = 1'b1;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("short_cnt", digit_cnt, 1);
    check("short_disp", display, 16'h0003);

    clear();
    check("clr_disp", display, 0);
    check("clr_cnt", digit_cnt, 0);

    for (int i = 1; i <= 5; i++) key(4'(i));
    check("five_disp", display, 16'h1234);
    check("five_cnt", digit_cnt, 4);

    clear();
    key(4'h3); key(4'hC); key(4'h0); key(4'h0);
    check("a_disp", display, 16'h3C00);
    enter();
    check("a_state", state, 1);
    check("a_op", op_a, 16'h3C00);
    check("a_cnt", digit_cnt, 0);
    key(4'h4); key(4'h0); key(4'h0); key(4'h0);
    starts = 0;
    enter();
    check("wait_state", state, 3);
    check("start_pulses", starts, 1);
    check("op_a", op_a, 16'h3C00);
    check("op_b", op_b, 16'h4000);
    check("wait_disp", display, 16'h4000);

    add_result = 16'h4200;
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
    @(negedge clk);
    check("res_state", state, 4);
    check("res_disp", display, 16'h4200);

    key(4'h7);
    check("restart_state", state, 0);
    check("restart_disp", display, 16'h0007);
    check("restart_cnt", digit_cnt, 1);

    enter();
    key(4'h1);
    enter();
    check("wait2_state", state, 3);
    clear();
    add_result = 16'h1111;
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_state", state, 0);
    check("abort_disp", display, 0);
    check("abort_ops", {op_a, op_b}, 0);

    key(4'h9);
    enter();
    key(4'h2);
    enter_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (state == 3'd2) found = 1'b1;
    end
    check("reach_start", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_start", add_start, 0);
    check("async_state", state, 0);
    check("async_ops", {op_a, op_b}, 0);
    check("async_disp", display, 0);
    check("async_cnt", digit_cnt, 0);
    enter_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_state", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_operand_ctrl.md
KEYPAD_OPERAND_CTRL -- requirements
Module: keypad_operand_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 16: consecutive clk samples required to accept a key or button press or release.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 key_value  input  4  hex digit from keypad decoder.
REQ-005 key_valid  input  1  key_value is a pressed, sensed key.
REQ-006 enter_btn  input  1  asynchronous pushbutton, active-high; commits current operand.
REQ-007 clear_btn  input  1  asynchronous pushbutton, active-high; aborts and clears all.
REQ-008 add_start  output  1  one-cycle pulse: op_a/op_b valid, start FP16 add.
REQ-009 op_a, op_b  output  16 each  latched FP16 operands.
REQ-010 add_done  input  1  one-cycle pulse from adder; add_result valid in same cycle.
REQ-011 add_result  input  16  FP16 sum.
REQ-012 display  output  16  value shown on 4-digit hex display.
REQ-013 state  output  3  current FSM state encoding (debug).
REQ-014 digit_cnt  output  3  digits entered into current operand, 0..4.

Function
REQ-015 enter_btn and clear_btn SHALL each pass a 2-flop synchronizer before any use.
REQ-016 A digit SHALL be accepted once, on the cycle key_valid has been high with an unchanged key_value for DEBOUNCE consecutive cycles; a change of key_value restarts the count.
REQ-017 No further digit SHALL be accepted until key_valid has been low for DEBOUNCE consecutive cycles (release re-arm).
REQ-018 Buttons SHALL generate one internal event on synchronized level high for DEBOUNCE cycles, re-armed after low for DEBOUNCE cycles.
REQ-019 Accepted digit in entry state: entry register SHALL shift left 4 and insert digit at [3:0]; digit_cnt increments; at digit_cnt==4 further digits SHALL be ignored (no shift, no wrap).
REQ-020 FSM states: ENTRY_A, ENTRY_B, START, WAIT, RESULT.
REQ-021 ENTRY_A + enter event: op_a <= entry register (0 if no digits), entry/digit_cnt cleared, -> ENTRY_B.
REQ-022 ENTRY_B + enter event: op_b <= entry register, -> START.
REQ-023 START: add_start high exactly one cycle, -> WAIT; op_a/op_b SHALL remain stable from START until the next ENTRY_A commit.
REQ-024 WAIT: on add_done, result register <= add_result, -> RESULT; digits and enter ignored in WAIT.
REQ-025 RESULT: enter ignored; an accepted digit SHALL -> ENTRY_A with entry register = {12'h000, digit}, digit_cnt=1.
REQ-026 Clear event SHALL take priority over all other events in the same cycle and, from any state, force ENTRY_A with entry, digit_cnt, op_a, op_b, result cleared.
REQ-027 add_done arriving outside WAIT (e.g. after clear aborted WAIT) SHALL be ignored.
REQ-028 display SHALL be the entry register in ENTRY_A/ENTRY_B, op_b in START/WAIT, result register in RESULT.
REQ-029 Simultaneous digit acceptance and enter event in an entry state: digit SHALL be shifted in first, then the updated value committed.

Reset
REQ-030 On rst_n low: state=ENTRY_A, add_start=0, op_a=op_b=display=0, digit_cnt=0, result=0, all debounce counters 0, synchronizers 0, all press detectors armed.
REQ-031 Deassertion mid-press SHALL require a full DEBOUNCE high period before acceptance.

Structure
REQ-032 Shared package keypad_pkg SHALL hold the state enum type, FP16 width constant (16) and digit-count width.
REQ-033 One sub-module, press_debounce (parameter DEBOUNCE; level in, one-cycle accept pulse out, with release re-arm), SHALL be instantiated for keypad, enter and clear; keypad instance additionally restarts on key_value change.

Verification
REQ-034 DEBOUNCE=4; key 0x3 held 10 cycles, released 6 -> exactly one accept, display=0x0003, digit_cnt=1.
REQ-035 Key 0x5 held 3 cycles then released -> no accept; digit_cnt unchanged.
REQ-036 Enter digits 1,2,3,4,5 -> display=0x1234, digit_cnt=4 (fifth ignored).
REQ-037 A=0x3C00, enter, B=0x4000, enter -> add_start one cycle, op_a=0x3C00, op_b=0x4000; add_done with 0x4200 -> state RESULT, display=0x4200.
REQ-038 Clear during WAIT, then add_done pulse -> state ENTRY_A, display=0x0000, result unchanged at 0.
REQ-039 rst_n low asynchronously in START -> add_start=0 immediately, state=ENTRY_A, all outputs 0.
